// File: rtl/arcade_pkg.sv
// Shared arcade graphics-path types: arbiter FSM states and LFSR defaults.
package arcade_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        SERVE = 1'b1
    } lfsr_state_t;

    localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h481;

endpackage

// File: rtl/lfsr_arbiter_if.sv
// Requester-side bus of the shared LFSR arbiter.
interface lfsr_arbiter_if
    import arcade_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter logic [31:0] POLY    = LFSR_POLY_DEFAULT
);
    localparam int unsigned W   = $clog2(POLY) - 1;
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               frame_start;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [W-1:0]       rnd_data;
    logic [IDW-1:0]     rnd_id;
    logic               rnd_valid;

    modport master (
        output frame_start, req,
        input  gnt, rnd_data, rnd_id, rnd_valid
    );

    modport slave (
        input  frame_start, req,
        output gnt, rnd_data, rnd_id, rnd_valid
    );

endinterface

// File: rtl/lfsr.sv
// Galois LFSR: init loads din zero-extended as the seed, en advances one step.
module lfsr #(
    parameter  logic [31:0] POLY = 32'h481,
    localparam int unsigned W    = $clog2(POLY) - 1
) (
    input  logic         clk,
    input  logic         en,
    input  logic         init,
    input  logic         din,
    output logic [W-1:0] lfsr
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    // init wins over en so a reseed is never mixed with a shift
    always_comb begin
        lfsr_d = lfsr_q;
        if (init) begin
            lfsr_d = W'(din);
        end else if (en) begin
            lfsr_d = {lfsr_q[W-2:0], 1'b0} ^ ({W{lfsr_q[W-1]}} & POLY[W-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        lfsr_q <= lfsr_d;
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter that hands out one shared LFSR value per grant and
// reseeds the LFSR on every frame_start so each frame replays the same stream.
module lfsr_arbiter
    import arcade_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter logic [31:0] POLY    = LFSR_POLY_DEFAULT
) (
    input logic          clk,
    input logic          reset,
    lfsr_arbiter_if.slave bus
);

    localparam int unsigned W   = $clog2(POLY) - 1;
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] S_INIT  = 1'(INIT);
    localparam logic [0:0] S_SERVE = 1'(SERVE);

    logic [0:0]         state_q,     state_d;
    logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic               rnd_valid_q, rnd_valid_d;
    logic [W-1:0]       rnd_data_q,  rnd_data_d;
    logic [IDW-1:0]     rnd_id_q,    rnd_id_d;

    logic [NUM_REQ-1:0] elig_c;
    logic [IDW-1:0]     win_c;
    logic               lfsr_init_c;
    logic               lfsr_en_c;
    logic [W-1:0]       lfsr_out_c;

    // First set bit at index >= ptr, wrapping modulo NUM_REQ
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                               input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] win;
        logic           found;
        int unsigned    idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && elig[IDW'(idx)]) begin
                win   = IDW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    lfsr #(.POLY(POLY)) u_lfsr (
        .clk  (clk),
        .en   (lfsr_en_c),
        .init (lfsr_init_c),
        .din  (1'b1),
        .lfsr (lfsr_out_c)
    );

    // Previous grantee is masked so it cannot win again while dropping req
    assign elig_c = bus.req & ~gnt_q;
    assign win_c  = rr_pick(elig_c, rr_ptr_q);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = '0;
        rnd_valid_d = 1'b0;
        rnd_data_d  = rnd_data_q;
        rnd_id_d    = rnd_id_q;
        lfsr_init_c = 1'b0;
        lfsr_en_c   = 1'b0;

        if (state_q == S_INIT) begin
            lfsr_init_c = 1'b1;
            state_d     = S_SERVE;
        end else if (bus.frame_start) begin
            state_d = S_INIT;
        end else if (|elig_c) begin
            gnt_d       = NUM_REQ'(1) << win_c;
            rnd_valid_d = 1'b1;
            rnd_data_d  = lfsr_out_c;
            rnd_id_d    = win_c;
            lfsr_en_c   = 1'b1;
            rr_ptr_d    = (win_c == IDW'(NUM_REQ - 1)) ? '0 : win_c + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_INIT;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= '0;
            rnd_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            rnd_id_q    <= rnd_id_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd_valid = rnd_valid_q;
    assign bus.rnd_data  = rnd_data_q;
    assign bus.rnd_id    = rnd_id_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter: per-cycle vector tables plus an async-reset sequence.
module tb_lfsr_arbiter;

    typedef struct {
        logic [3:0] req;
        logic       fs;
        logic [3:0] gnt;
        logic       valid;
        logic [9:0] data;
        logic [1:0] id;
    } row_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    row_t rows_a[$];
    row_t rows_b[$];

    lfsr_arbiter_if #(.NUM_REQ(4)) bus ();

    lfsr_arbiter #(.NUM_REQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(input logic [3:0] req, input logic fs, input logic [3:0] gnt,
                                input logic valid, input logic [9:0] data, input logic [1:0] id);
        row_t r;
        r.req   = req;
        r.fs    = fs;
        r.gnt   = gnt;
        r.valid = valid;
        r.data  = data;
        r.id    = id;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int idx, input row_t r);
        chk({tag, ".gnt"},   idx, 32'(bus.gnt),       32'(r.gnt));
        chk({tag, ".valid"}, idx, 32'(bus.rnd_valid), 32'(r.valid));
        chk({tag, ".data"},  idx, 32'(bus.rnd_data),  32'(r.data));
        chk({tag, ".id"},    idx, 32'(bus.rnd_id),    32'(r.id));
    endtask

    // Inputs change at negedge, outputs of the following posedge are checked at the next negedge
    task automatic apply_row(input string tag, input int idx, input row_t r);
        bus.req         = r.req;
        bus.frame_start = r.fs;
        @(negedge clk);
        chk_outs(tag, idx, r);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        bus.req         = 4'b0000;
        bus.frame_start = 1'b0;

        // LFSR sequence after seed: 001 002 004 008 010 020 040 080 ...
        // Single requester held: INIT cycle, then a grant every second cycle
        rows_a.push_back(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 10'h000, 2'd0));
        rows_a.push_back(mk(4'b0001, 1'b0, 4'b0001, 1'b1, 10'h001, 2'd0));
        rows_a.push_back(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 10'h001, 2'd0));
        rows_a.push_back(mk(4'b0001, 1'b0, 4'b0001, 1'b1, 10'h002, 2'd0));
        rows_a.push_back(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 10'h002, 2'd0));
        rows_a.push_back(mk(4'b0001, 1'b0, 4'b0001, 1'b1, 10'h004, 2'd0));

        // After async reset: all four requesting, rotate one grant per cycle
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b0000, 1'b0, 10'h000, 2'd0));
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b0001, 1'b1, 10'h001, 2'd0));
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b0010, 1'b1, 10'h002, 2'd1));
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b0100, 1'b1, 10'h004, 2'd2));
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b1000, 1'b1, 10'h008, 2'd3));
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b0001, 1'b1, 10'h010, 2'd0));
        // Grant to 2 leaves pointer at 3; then 0011 must wrap to requester 0
        rows_b.push_back(mk(4'b0100, 1'b0, 4'b0100, 1'b1, 10'h020, 2'd2));
        rows_b.push_back(mk(4'b0011, 1'b0, 4'b0001, 1'b1, 10'h040, 2'd0));
        // Pointer now 1: of 0110, requester 1 wins
        rows_b.push_back(mk(4'b0110, 1'b0, 4'b0010, 1'b1, 10'h080, 2'd1));
        rows_b.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 10'h080, 2'd1));
        // frame_start with pending requests, second pulse lands in INIT
        rows_b.push_back(mk(4'b1111, 1'b1, 4'b0000, 1'b0, 10'h080, 2'd1));
        rows_b.push_back(mk(4'b1111, 1'b1, 4'b0000, 1'b0, 10'h080, 2'd1));
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b0100, 1'b1, 10'h001, 2'd2));
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b1000, 1'b1, 10'h002, 2'd3));
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b0001, 1'b1, 10'h004, 2'd0));
        // Second frame replays the same data sequence
        rows_b.push_back(mk(4'b1111, 1'b1, 4'b0000, 1'b0, 10'h004, 2'd0));
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b0000, 1'b0, 10'h004, 2'd0));
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b0010, 1'b1, 10'h001, 2'd1));
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b0100, 1'b1, 10'h002, 2'd2));
        rows_b.push_back(mk(4'b1111, 1'b0, 4'b1000, 1'b1, 10'h004, 2'd3));
        rows_b.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 10'h004, 2'd3));

        @(negedge clk);
        @(negedge clk);
        chk_outs("reset", 0, mk(4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000, 2'd0));
        reset = 1'b0;

        for (int i = 0; i < rows_a.size(); i++) begin
            apply_row("single", i, rows_a[i]);
        end

        // Async reset between edges: outputs must clear before the next posedge
        bus.req = 4'b0000;
        #2 reset = 1'b1;
        #1 chk_outs("async_rst", 0, mk(4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000, 2'd0));
        @(negedge clk);
        chk_outs("async_rst", 1, mk(4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000, 2'd0));
        reset = 1'b0;

        for (int i = 0; i < rows_b.size(); i++) begin
            apply_row("multi", i, rows_b[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
